ans_decoder: RTL



---
 rtl/ans_decoder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ans_decoder.sv
// Streaming rANS decoder: rebuilds 4-bit symbols from the reversed nibble stream
// of the ANS encoder, using the shared 16-entry count table.
module ans_decoder #(
  parameter int SYM_WIDTH  = 4,
  parameter int CNT_WIDTH  = 4,
  parameter int PROB_BITS  = 6,
  parameter int STATE_BITS = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [LEN_WIDTH-1:0]                    num_syms,
  input  logic [(1<<SYM_WIDTH)*CNT_WIDTH-1:0]     counts,
  input  logic [SYM_WIDTH-1:0]                    in,
  input  logic                                    in_vld,
  output logic                                    in_rdy,
  output logic [SYM_WIDTH-1:0]                    out,
  output logic                                    out_vld,
  input  logic                                    out_rdy,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    ok
);

  // state    | meaning
  // S_IDLE   | waiting for start
  // S_INIT   | loading the initial state, MSB nibble first
  // S_DECODE | slot lookup and state update
  // S_EMIT   | presenting the decoded symbol
  // S_RENORM | pulling nibbles until x >= L
  // S_DONE   | one-cycle end-of-run pulse
  typedef enum logic [2:0] {S_IDLE, S_INIT, S_DECODE, S_EMIT, S_RENORM, S_DONE} state_t;

  localparam int NSYM  = 1 << SYM_WIDTH;
  localparam int NIB   = STATE_BITS / SYM_WIDTH;
  localparam int NW    = $clog2(NIB);
  localparam int ACC_W = CNT_WIDTH + SYM_WIDTH;
  localparam logic [STATE_BITS-1:0] L = STATE_BITS'(1) << (STATE_BITS - SYM_WIDTH);

  state_t                state, state_nxt;
  logic [STATE_BITS-1:0] x;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [NW-1:0]         nib_cnt;
  logic                  err;

  logic [PROB_BITS-1:0]  slot;
  logic [ACC_W-1:0]      acc, sel_cum;
  logic [CNT_WIDTH-1:0]  f_i, sel_f;
  logic [SYM_WIDTH-1:0]  sel_sym;
  logic                  hit;
  logic [STATE_BITS-1:0] x_dec, x_shift;

  assign slot    = x[PROB_BITS-1:0];
  assign x_shift = {x[STATE_BITS-SYM_WIDTH-1:0], in};
  assign x_dec   = STATE_BITS'(sel_f) * (x >> PROB_BITS) + STATE_BITS'(slot) - STATE_BITS'(sel_cum);

  // Running cumulative sum; accumulator is wide enough for malformed tables.
  always_comb begin
    acc     = '0;
    f_i     = '0;
    hit     = 1'b0;
    sel_sym = '1;
    sel_f   = '0;
    sel_cum = '0;
    for (int i = 0; i < NSYM; i++) begin
      f_i = counts[i*CNT_WIDTH +: CNT_WIDTH];
      if (f_i != '0 && ACC_W'(slot) >= acc && ACC_W'(slot) < acc + ACC_W'(f_i)) begin
        hit     = 1'b1;
        sel_sym = SYM_WIDTH'(i);
        sel_f   = f_i;
        sel_cum = acc;
      end
      acc = acc + ACC_W'(f_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    out_vld   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (num_syms != '0) ? S_INIT : S_DONE;
      end
      S_INIT: begin
        in_rdy = 1'b1;
        if (in_vld && nib_cnt == NW'(NIB - 1)) state_nxt = S_DECODE;
      end
      S_DECODE: state_nxt = S_EMIT;
      S_EMIT: begin
        out_vld = 1'b1;
        if (out_rdy) begin
          if (remaining == LEN_WIDTH'(1)) state_nxt = S_DONE;
          else if (x < L)                  state_nxt = S_RENORM;
          else                             state_nxt = S_DECODE;
        end
      end
      S_RENORM: begin
        in_rdy = 1'b1;
        if (in_vld && x_shift >= L) state_nxt = S_DECODE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x         <= '0;
      remaining <= '0;
      nib_cnt   <= '0;
      out       <= '0;
      ok        <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          x         <= '0;
          remaining <= num_syms;
          nib_cnt   <= '0;
          ok        <= 1'b0;
          err       <= 1'b0;
        end
        S_INIT: if (in_vld) begin
          x       <= x_shift;
          nib_cnt <= nib_cnt + NW'(1);
        end
        S_DECODE: begin
          out <= sel_sym;
          if (hit) x <= x_dec;
          else     err <= 1'b1;
        end
        S_EMIT: if (out_rdy) begin
          remaining <= remaining - LEN_WIDTH'(1);
          // x is final here: no renormalisation follows the last symbol
          if (remaining == LEN_WIDTH'(1)) ok <= (x == L) && !err;
        end
        S_RENORM: if (in_vld) x <= x_shift;
        default: ;
      endcase
    end
  end

endmodule
